hazard_unit_ml: RTL
===================

// Module: hazard_unit_ml
// PURPOSE
//  Parametrised hazard unit for the 5-stage ARM pipeline (F/D/E/M/W). Compares register addresses
//  internally to produce forwarding selects. Generates load-use, branch and PC-write stalls/flushes.
//  Adds a sequential multi-cycle memory wait controller that freezes F..M while a load occupies M.
//  Sits beside the datapath; drives pipeline-register enables/clears and the E-stage operand muxes.
// PARAMETERS
//  RA_W     4   register address width
//  PC_REG   15  register index of PC; a source equal to PC_REG is never forwarded
//  MEM_LAT  1   cycles a load spends in M before read data is valid (>=1); 1 = no memory stall
//  CNT_W    4   wait counter width; requires 2**CNT_W > MEM_LAT
// PORTS
//  clk           in  1     clock, all state updates on rising edge
//  reset         in  1     synchronous, active-low reset
//  RA1D,RA2D     in  RA_W  decode-stage source registers
//  RA1E,RA2E     in  RA_W  execute-stage source registers
//  WA3E,WA3M,WA3W in RA_W  destination register in E/M/W
//  RegWriteE/M/W in  1     destination write enable in E/M/W
//  MemtoRegE/M   in  1     instruction in E/M is a load
//  BranchTakenE  in  1     branch resolved taken in E
//  PCWrPendingF  in  1     a PC-writing instruction is in D/E/M
//  PCSrcW        in  1     PC written from W this cycle
//  ForwardAE,ForwardBE out 2  00 regfile, 01 ResultW, 10 ALUResultM
//  StallF,StallD,StallE,StallM out 1  hold pipeline register
//  FlushD,FlushE,FlushW out 1  clear pipeline register to a bubble
// BEHAVIOUR
//  Forwarding (comb): ForwardXE=10 if RAxE==WA3M & RegWriteM & ~MemtoRegM & RAxE!=PC_REG;
//   else 01 if RAxE==WA3W & RegWriteW & RAxE!=PC_REG; else 00. M has priority over W.
//  ldrStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
//  Memory FSM, states IDLE/WAIT, counter cnt[CNT_W]:
//   IDLE: if MemtoRegM & MEM_LAT>1 -> memStall=1, cnt<=1, next WAIT; else memStall=0.
//   WAIT: if cnt==MEM_LAT-1 -> memStall=0, next IDLE (load advances to W this edge);
//         else memStall=1, cnt<=cnt+1.
//   Net: exactly MEM_LAT-1 stall cycles per load. Back-to-back loads each take MEM_LAT-1 stalls:
//   the IDLE cycle after release sees the new M instruction.
//  memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1.
//   FlushD, FlushE, ldrStall and BranchTakenE effects are masked; the branch in E is frozen and acts on release.
//  memStall=0: StallM=StallE=0, FlushW=0, StallD=ldrStall, StallF=ldrStall|PCWrPendingF,
//   FlushE=ldrStall|BranchTakenE, FlushD=PCWrPendingF|PCSrcW|BranchTakenE.
//  PCSrcW overrides: when PCSrcW=1, StallF=0 and FlushD=1 regardless of memStall.
//   This keeps the redirect from being lost.
//  Flush and stall on the same register: flush wins (datapath contract).
//  Reset (reset==0 at edge): state<=IDLE, cnt<=0. While reset is low, outputs are forced to:
//   Forward*=00, all Stall*=0, FlushD=FlushE=FlushW=1. Reset mid-wait aborts the wait.
//  cnt never wraps: held to 1..MEM_LAT-1 by the FSM.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs StallCycles[31:0] and FlushCycles[31:0]. Both are 0 on reset.
//   StallCycles increments each cycle StallF=1. FlushCycles increments each cycle FlushD|FlushE=1.
//   Both saturate at 32'hFFFF_FFFF.
//  HAZARD_PERF_EN undefined: the ports and counters do not exist. Remaining behaviour is identical.
// TESTING
//  1 Fwd: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10.
//    With RA1E=15 -> 00. With MemtoRegM=1, MEM_LAT=1 -> 01.
//  2 Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for 1 cycle. RA2D=6 -> all 0.
//  3 MEM_LAT=3: load enters M -> StallF..StallM=1 and FlushW=1 for exactly 2 cycles, then 0.
//    Back-to-back load -> 2 more stall cycles.
//  4 BranchTakenE=1 during memStall -> FlushD=FlushE=0. On the release cycle -> FlushD=FlushE=1.
//  5 PCSrcW=1 during memStall -> StallF=0, FlushD=1 that cycle.
//    Reset low in WAIT -> next cycle IDLE, stalls 0.
//  6 HAZARD_PERF_EN: 2 load-use stalls + 1 branch -> StallCycles=2, FlushCycles=3. Reset -> both 0.

Source files
------------

// File: rtl/hazard_unit_ml.sv
// hazard_unit_ml: forwarding, stall and flush control for the 5-stage ARM pipeline
// with a multi-cycle memory wait controller. Define HAZARD_PERF_EN to add the
// StallCycles/FlushCycles performance counters.
module hazard_unit_ml #(
   parameter int RA_W    = 4,
   parameter int PC_REG  = 15,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RA_W-1:0] RA1D,
   input  logic [RA_W-1:0] RA2D,
   input  logic [RA_W-1:0] RA1E,
   input  logic [RA_W-1:0] RA2E,
   input  logic [RA_W-1:0] WA3E,
   input  logic [RA_W-1:0] WA3M,
   input  logic [RA_W-1:0] WA3W,
   input  logic            RegWriteE,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   input  logic            MemtoRegE,
   input  logic            MemtoRegM,
   input  logic            BranchTakenE,
   input  logic            PCWrPendingF,
   input  logic            PCSrcW,
   output logic [1:0]      ForwardAE,
   output logic [1:0]      ForwardBE,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            StallM,
   output logic            FlushD,
   output logic            FlushE,
`ifdef HAZARD_PERF_EN
   output logic [31:0]     StallCycles,
   output logic [31:0]     FlushCycles,
`endif
   output logic            FlushW
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [RA_W-1:0]  PC_IDX   = RA_W'(PC_REG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam bit               MULTI    = (MEM_LAT > 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_stall;
   logic             ldr_stall;

   // The PC is never forwarded; it is supplied by the datapath directly.
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra);
      if (ra != PC_IDX && ra == WA3M && RegWriteM && !MemtoRegM)
         return 2'b10;
      if (ra != PC_IDX && ra == WA3W && RegWriteW)
         return 2'b01;
      return 2'b00;
   endfunction

   // Operand forwarding selects; M beats W, all forced to regfile during reset.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (reset) begin
         ForwardAE = fwd_sel(RA1E);
         ForwardBE = fwd_sel(RA2E);
      end
   end

   // Memory wait controller: holds a load in M for MEM_LAT-1 extra cycles.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      if (state_q == IDLE) begin
         if (MemtoRegM && MULTI) begin
            mem_stall = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = WAIT;
         end
      end else if (cnt_q == CNT_LAST) begin
         state_d = IDLE;
      end else begin
         mem_stall = 1'b1;
         cnt_d     = cnt_q + CNT_W'(1);
      end
   end

   // Wait controller state register; reset aborts any wait in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall/flush generation; a memory stall freezes F..M and masks branch/load-use effects.
   always_comb begin
      ldr_stall = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      if (reset) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
         end else begin
            StallD = ldr_stall;
            StallF = ldr_stall || PCWrPendingF;
            FlushE = ldr_stall || BranchTakenE;
            FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
            FlushW = 1'b0;
         end
         if (PCSrcW) begin
            StallF = 1'b0;
            FlushD = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating counts of fetch-stall cycles and front-end flush cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if ((FlushD || FlushE) && flush_cnt_q != 32'hFFFF_FFFF)
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   // Counter registers, cleared while reset is low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCycles = stall_cnt_q;
   assign FlushCycles = flush_cnt_q;
`endif

endmodule
